// File: rtl/display_buffer_ctrl_pkg.sv
// display_pkg: shared types and default sizing for the ping-pong frame-buffer
// controller and its parent (topdisplay).
//   buf_state_t  : per-buffer ownership state
//   scan_state_t : scan-out FSM state
package display_pkg;

  typedef enum logic [1:0] {
    EMPTY      = 2'd0,
    FILLING    = 2'd1,
    FULL       = 2'd2,
    DISPLAYING = 2'd3
  } buf_state_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    VBLANK = 2'd2
  } scan_state_t;

  localparam int DEFAULT_FRAME_LEN  = 120;
  localparam int DEFAULT_VBLANK_LEN = 4;

endpackage

// File: rtl/display_buffer_ctrl_if.sv
// display_buffer_ctrl_if: writer handshake plus buffer-memory write/read
// address bus of the frame-buffer controller.
//   master : the controller (drives wr_ready/wr_en/addresses/rd_en)
//   slave  : writer + buffer memories (drive wr_valid)
interface display_buffer_ctrl_if #(
  parameter int ADDR_W = 7
) ();
  logic              wr_valid;
  logic              wr_ready;
  logic              wr_en;
  logic              wr_buf;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_en;
  logic              rd_buf;
  logic [ADDR_W-1:0] rd_addr;

  modport master (
    input  wr_valid,
    output wr_ready, wr_en, wr_buf, wr_addr,
    output rd_en, rd_buf, rd_addr
  );

  modport slave (
    output wr_valid,
    input  wr_ready, wr_en, wr_buf, wr_addr,
    input  rd_en, rd_buf, rd_addr
  );
endinterface

// File: rtl/display_buffer_ctrl_counter.sv
// frame_addr_counter: pixel address counter 0..FRAME_LEN-1 that wraps to 0.
//   clk, reset (async active-low), en : advance one address
//   addr : current address            last : addr is FRAME_LEN-1
module frame_addr_counter #(
  parameter int FRAME_LEN = 8,
  parameter int ADDR_W    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  assign last = (addr == LAST_ADDR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  addr <= '0;
    else if (en) addr <= last ? '0 : addr + ADDR_W'(1);
  end
endmodule

// File: rtl/display_buffer_ctrl.sv
// display_buffer_ctrl: ping-pong frame-buffer arbiter between the pixel writer
// and display scan-out. Generates write/read addresses, tracks buffer fill
// state, produces the vertical-blank interval. Never touches pixel data.
//   clk, reset (async active-low)
//   CSDisplay          : display enable, sampled in IDLE only
//   bus (master)       : writer handshake, write/read strobes, buffers, addresses
//   SyncVB             : high during vertical blank
//   Buf0Empty/Buf1Empty: buffer is EMPTY
//
// Scan FSM:
//   state  | meaning
//   IDLE   | waiting for CSDisplay and a FULL buffer at rd_buf
//   SCAN   | reading rd_buf, one address per cycle
//   VBLANK | SyncVB high for VBLANK_LEN cycles
module display_buffer_ctrl
  import display_pkg::*;
#(
  parameter int FRAME_LEN  = DEFAULT_FRAME_LEN,
  parameter int VBLANK_LEN = DEFAULT_VBLANK_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic CSDisplay,
  display_buffer_ctrl_if.master bus,
  output logic SyncVB,
  output logic Buf0Empty,
  output logic Buf1Empty
);
  localparam int ADDR_W = $clog2(FRAME_LEN);
  localparam int VB_W   = $clog2(VBLANK_LEN + 1);

  buf_state_t        buf_st  [2];
  buf_state_t        buf_nxt [2];
  scan_state_t       state, state_nxt;
  logic [VB_W-1:0]   vb_cnt, vb_cnt_nxt;
  logic              wr_buf_q, wr_buf_nxt;
  logic              rd_buf_q, rd_buf_nxt;
  logic              rd_en_q, sync_vb_q, empty0_q, empty1_q;
  logic              wr_ready, wr_en, wr_last, rd_last;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  assign wr_ready = (buf_st[wr_buf_q] == EMPTY) || (buf_st[wr_buf_q] == FILLING);
  assign wr_en    = bus.wr_valid & wr_ready;

  frame_addr_counter #(.FRAME_LEN(FRAME_LEN), .ADDR_W(ADDR_W)) u_wr_cnt (
    .clk(clk), .reset(reset), .en(wr_en), .addr(wr_addr), .last(wr_last)
  );

  frame_addr_counter #(.FRAME_LEN(FRAME_LEN), .ADDR_W(ADDR_W)) u_rd_cnt (
    .clk(clk), .reset(reset), .en(state == SCAN), .addr(rd_addr), .last(rd_last)
  );

  // Writer and reader never touch the same buffer in one cycle: the writer
  // only owns EMPTY/FILLING buffers, the reader only FULL/DISPLAYING ones.
  always_comb begin
    buf_nxt    = buf_st;
    state_nxt  = state;
    vb_cnt_nxt = vb_cnt;
    wr_buf_nxt = wr_buf_q;
    rd_buf_nxt = rd_buf_q;

    if (wr_en) begin
      if (wr_last) begin
        buf_nxt[wr_buf_q] = FULL;
        wr_buf_nxt        = ~wr_buf_q;
      end else begin
        buf_nxt[wr_buf_q] = FILLING;
      end
    end

    case (state)
      IDLE: begin
        if (CSDisplay && buf_st[rd_buf_q] == FULL) begin
          state_nxt         = SCAN;
          buf_nxt[rd_buf_q] = DISPLAYING;
        end
      end
      SCAN: begin
        if (rd_last) begin
          state_nxt         = VBLANK;
          buf_nxt[rd_buf_q] = EMPTY;
          rd_buf_nxt        = ~rd_buf_q;
          vb_cnt_nxt        = VB_W'(VBLANK_LEN - 1);
        end
      end
      VBLANK: begin
        if (vb_cnt == '0) state_nxt = IDLE;
        else              vb_cnt_nxt = vb_cnt - VB_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_st[0] <= EMPTY;
      buf_st[1] <= EMPTY;
      state     <= IDLE;
      vb_cnt    <= '0;
      wr_buf_q  <= 1'b0;
      rd_buf_q  <= 1'b0;
      rd_en_q   <= 1'b0;
      sync_vb_q <= 1'b0;
      empty0_q  <= 1'b1;
      empty1_q  <= 1'b1;
    end else begin
      buf_st[0] <= buf_nxt[0];
      buf_st[1] <= buf_nxt[1];
      state     <= state_nxt;
      vb_cnt    <= vb_cnt_nxt;
      wr_buf_q  <= wr_buf_nxt;
      rd_buf_q  <= rd_buf_nxt;
      rd_en_q   <= (state_nxt == SCAN);
      sync_vb_q <= (state_nxt == VBLANK);
      empty0_q  <= (buf_nxt[0] == EMPTY);
      empty1_q  <= (buf_nxt[1] == EMPTY);
    end
  end

  assign bus.wr_ready = wr_ready;
  assign bus.wr_en    = wr_en;
  assign bus.wr_buf   = wr_buf_q;
  assign bus.wr_addr  = wr_addr;
  assign bus.rd_en    = rd_en_q;
  assign bus.rd_buf   = rd_buf_q;
  assign bus.rd_addr  = rd_addr;
  assign SyncVB       = sync_vb_q;
  assign Buf0Empty    = empty0_q;
  assign Buf1Empty    = empty1_q;
endmodule

// File: tb/tb_display_buffer_ctrl.sv
// Directed bench for display_buffer_ctrl with FRAME_LEN=8, VBLANK_LEN=2.
module tb_display_buffer_ctrl;
  localparam int FL = 8;
  localparam int VL = 2;
  localparam int AW = $clog2(FL);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic CSDisplay = 1'b0;
  logic SyncVB, Buf0Empty, Buf1Empty;

  int n_tests = 0;
  int n_fail  = 0;

  display_buffer_ctrl_if #(.ADDR_W(AW)) bus ();

  display_buffer_ctrl #(.FRAME_LEN(FL), .VBLANK_LEN(VL)) dut (
    .clk(clk), .reset(reset), .CSDisplay(CSDisplay), .bus(bus),
    .SyncVB(SyncVB), .Buf0Empty(Buf0Empty), .Buf1Empty(Buf1Empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.wr_valid = 1'b0;
    CSDisplay = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, saw, prev, nstart;
    int starts [3];
    int bufs   [3];

    // 1. reset
    do_reset();
    #1;
    check("rst_empty0", Buf0Empty, 1);
    check("rst_empty1", Buf1Empty, 1);
    check("rst_wr_ready", bus.wr_ready, 1);
    check("rst_rd_en", bus.rd_en, 0);
    check("rst_syncvb", SyncVB, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_rd_addr", bus.rd_addr, 0);
    check("rst_wr_buf", bus.wr_buf, 0);
    check("rst_rd_buf", bus.rd_buf, 0);

    // 2. fill buffer 0 then display it
    bus.wr_valid = 1'b1;
    for (int i = 0; i < FL; i++) begin
      #1;
      check("fill_wr_addr", bus.wr_addr, i);
      check("fill_wr_buf", bus.wr_buf, 0);
      check("fill_wr_en", bus.wr_en, 1);
      check("fill_empty0", Buf0Empty, (i == 0) ? 1 : 0);
      step();
    end
    bus.wr_valid = 1'b0;
    CSDisplay = 1'b1;
    #1;
    check("fill_done_wr_addr", bus.wr_addr, 0);
    check("fill_done_wr_buf", bus.wr_buf, 1);
    check("fill_done_rd_en", bus.rd_en, 0);
    step();
    for (int j = 0; j < FL; j++) begin
      check("scan_rd_en", bus.rd_en, 1);
      check("scan_rd_addr", bus.rd_addr, j);
      check("scan_rd_buf", bus.rd_buf, 0);
      check("scan_syncvb", SyncVB, 0);
      step();
    end
    check("vb1_syncvb", SyncVB, 1);
    check("vb1_empty0", Buf0Empty, 1);
    check("vb1_rd_en", bus.rd_en, 0);
    check("vb1_rd_buf", bus.rd_buf, 1);
    step();
    check("vb2_syncvb", SyncVB, 1);
    step();
    check("vb_end_syncvb", SyncVB, 0);
    saw = 0;
    repeat (5) begin
      if (bus.rd_en) saw = 1;
      step();
    end
    check("underrun_no_rd", saw, 0);

    // 3. backpressure
    do_reset();
    bus.wr_valid = 1'b1;
    acc = 0;
    saw = 0;
    repeat (20) begin
      #1;
      if (bus.wr_en) acc++;
      if (bus.rd_en) saw = 1;
      step();
    end
    #1;
    check("bp_accepts", acc, 2 * FL);
    check("bp_wr_ready", bus.wr_ready, 0);
    check("bp_empty0", Buf0Empty, 0);
    check("bp_empty1", Buf1Empty, 0);
    check("bp_no_rd", saw, 0);

    // 4. enable drop mid-scan
    bus.wr_valid = 1'b0;
    CSDisplay = 1'b1;
    step();
    for (int j = 0; j < FL; j++) begin
      check("drop_rd_en", bus.rd_en, 1);
      check("drop_rd_addr", bus.rd_addr, j);
      if (j == 3) CSDisplay = 1'b0;
      step();
    end
    check("drop_vb1", SyncVB, 1);
    step();
    check("drop_vb2", SyncVB, 1);
    step();
    saw = 0;
    repeat (10) begin
      if (bus.rd_en) saw = 1;
      step();
    end
    check("drop_no_2nd_frame", saw, 0);
    check("drop_empty1", Buf1Empty, 0);
    check("drop_empty0", Buf0Empty, 1);
    check("drop_rd_buf", bus.rd_buf, 1);

    // 5. streaming
    do_reset();
    bus.wr_valid = 1'b1;
    CSDisplay = 1'b1;
    prev = 0;
    nstart = 0;
    for (int c = 0; c < 45; c++) begin
      if (bus.rd_en && prev == 0 && nstart < 3) begin
        starts[nstart] = c;
        bufs[nstart]   = int'(bus.rd_buf);
        nstart++;
      end
      prev = int'(bus.rd_en);
      step();
    end
    check("stream_frames", nstart, 3);
    if (nstart == 3) begin
      check("stream_first_start", starts[0], FL + 1);
      check("stream_buf0", bufs[0], 0);
      check("stream_buf1", bufs[1], 1);
      check("stream_buf2", bufs[2], 0);
      check("stream_period1", starts[1] - starts[0], FL + VL + 1);
      check("stream_period2", starts[2] - starts[1], FL + VL + 1);
    end

    // 6. reset mid-scan
    do_reset();
    bus.wr_valid = 1'b1;
    repeat (FL) step();
    bus.wr_valid = 1'b0;
    CSDisplay = 1'b1;
    step();
    repeat (5) step();
    check("mid_rd_addr", bus.rd_addr, 5);
    check("mid_rd_en", bus.rd_en, 1);
    #1;
    reset = 1'b0;
    #1;
    check("mrst_rd_en", bus.rd_en, 0);
    check("mrst_syncvb", SyncVB, 0);
    check("mrst_rd_addr", bus.rd_addr, 0);
    check("mrst_wr_addr", bus.wr_addr, 0);
    check("mrst_empty0", Buf0Empty, 1);
    check("mrst_empty1", Buf1Empty, 1);
    check("mrst_wr_ready", bus.wr_ready, 1);
    check("mrst_rd_buf", bus.rd_buf, 0);
    check("mrst_wr_buf", bus.wr_buf, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    saw = 0;
    repeat (12) begin
      if (bus.rd_en) saw = 1;
      step();
    end
    check("mrst_no_scan", saw, 0);
    bus.wr_valid = 1'b1;
    repeat (FL) step();
    bus.wr_valid = 1'b0;
    saw = 0;
    for (int k = 0; k < 5 && saw == 0; k++) begin
      if (bus.rd_en) saw = 1;
      else step();
    end
    check("mrst_rescan", saw, 1);
    check("mrst_rescan_buf", bus.rd_buf, 0);
    check("mrst_rescan_addr", bus.rd_addr, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/display_buffer_ctrl.md
# display_buffer_ctrl

Ping-pong frame-buffer controller for the display adaptor. It arbitrates the two pixel buffers between the upstream pixel writer and the display scan-out. It generates write and read addresses, tracks each buffer's fill state and produces the `SyncVB` vertical-blank interval and the `Buf0Empty` / `Buf1Empty` flags seen at the adaptor top level. It sits between the writer interface and the dual buffer memories inside `topdisplay`; it does not touch pixel data.

## Interface
Parameters:
- `FRAME_LEN`, default 120: pixels per frame, must be ≥ 2.
- `VBLANK_LEN`, default 4: cycles of vertical blank after each frame, must be ≥ 1.
- `ADDR_W`, default `$clog2(FRAME_LEN)`: address width, localparam.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; all state clears while `reset`=0.
- `CSDisplay` in 1: display enable, sampled only when the scan FSM is in IDLE.
- `wr_valid` in 1: writer offers a pixel.
- `wr_ready` out 1: a pixel is accepted in the same cycle when `wr_valid` & `wr_ready`.
- `wr_en` out 1: `wr_valid` & `wr_ready`, write strobe to the buffer memory.
- `wr_buf` out 1: target buffer for the write (0/1).
- `wr_addr` out `ADDR_W`: write address.
- `rd_en` out 1: registered read strobe; memory data returns externally one cycle later.
- `rd_buf` out 1: buffer being scanned.
- `rd_addr` out `ADDR_W`: read address.
- `SyncVB` out 1: high for every vertical-blank cycle.
- `Buf0Empty`, `Buf1Empty` out 1: buffer state is EMPTY.

## Operation
- Each buffer has a 2-bit state: EMPTY → FILLING → FULL → DISPLAYING → EMPTY. Each state is only ever advanced by the side that owns that transition.
- Writer side:
  - `wr_ready` = state[`wr_buf`] ∈ {EMPTY, FILLING}, decoded combinationally from registered state.
  - The first accept moves the buffer EMPTY→FILLING. Each accept increments `wr_addr`.
  - The accept at `wr_addr`=`FRAME_LEN`-1 moves the buffer to FULL, toggles `wr_buf` and wraps `wr_addr` to 0.
- Scan FSM has three states: IDLE, SCAN, VBLANK.
  - IDLE → SCAN when `CSDisplay`=1 and state[`rd_buf`]=FULL. The buffer goes to DISPLAYING and `rd_addr`=0.
  - SCAN: `rd_en`=1 every cycle and `rd_addr` increments. After the read at `FRAME_LEN`-1, go to VBLANK, the buffer goes to EMPTY and `rd_buf` toggles.
  - VBLANK: `SyncVB`=1 for `VBLANK_LEN` cycles, then go to IDLE.
- `CSDisplay` falling during SCAN or VBLANK does not abort the frame; it only blocks the next frame start.
- Underrun: in IDLE with no FULL buffer, the FSM stays in IDLE with `rd_en`=0. No partial (FILLING) buffer is ever scanned.
- Simultaneous events:
  - The writer completing one buffer and the reader releasing the other in the same cycle are both applied.
  - A buffer released to EMPTY becomes writable on the next cycle, not the same cycle.
  - A buffer becoming FULL can start a scan no earlier than the next cycle.
- Reset values: both buffers EMPTY, `wr_buf`=`rd_buf`=0, both addresses 0, FSM in IDLE, `rd_en`=0, `SyncVB`=0, `Buf0Empty`=`Buf1Empty`=1, `wr_ready`=1.
- Reset asserted mid-operation returns all outputs to these values asynchronously; any in-flight frame is discarded.

## Timing
- Write latency: an accepted pixel updates `wr_addr` on the next edge. There are no bubbles; one pixel per cycle is sustained while a buffer is writable.
- First `rd_en` occurs 1 cycle after IDLE sees the start condition.
- A frame is `FRAME_LEN` `rd_en` cycles, then `VBLANK_LEN` `SyncVB` cycles, then at least 1 IDLE cycle. The minimum frame period is `FRAME_LEN`+`VBLANK_LEN`+1 cycles.
- `Buf*Empty` falls in the cycle after the first accept. It rises in the first VBLANK cycle.
- All outputs are registered except `wr_ready` and `wr_en`.

## Structure
- `display_pkg` holds:
  - `buf_state_t` (EMPTY, FILLING, FULL, DISPLAYING).
  - `scan_state_t` (IDLE, SCAN, VBLANK).
  - Default `FRAME_LEN` and `VBLANK_LEN` constants shared with `topdisplay`.
- One sub-module, `frame_addr_counter` (enable, wrap at `FRAME_LEN`-1, `last` flag). It is instantiated twice, once for the write address and once for the read address.

## Test plan
All scenarios use `FRAME_LEN`=8 and `VBLANK_LEN`=2.
1. Reset: hold `reset`=0 for 3 cycles, then release → `Buf0Empty`=`Buf1Empty`=1, `wr_ready`=1, `rd_en`=0, `SyncVB`=0, all addresses 0.
2. Fill then display: `wr_valid`=1 for 8 cycles, then `CSDisplay`=1 → `wr_addr` 0..7 on `wr_buf`=0, then `wr_buf`=1. `Buf0Empty` is 0 from cycle 2. `rd_en` runs 8 cycles with `rd_addr` 0..7 and `rd_buf`=0, then `SyncVB`=1 for 2 cycles with `Buf0Empty`=1 in the first of them.
3. Backpressure: with `CSDisplay`=0, hold `wr_valid`=1 for 20 cycles → exactly 16 accepts, then `wr_ready`=0, both empty flags 0, `rd_en` never asserted.
4. Enable drop: deassert `CSDisplay` at `rd_addr`=3 → the scan still completes through `rd_addr`=7 and VBLANK. No second frame starts although buffer 1 is FULL.
5. Streaming: continuous `wr_valid` and `CSDisplay`=1 → `rd_buf` alternates 0,1,0. Period is 11 cycles. There is no IDLE underrun after the first frame.
6. Mid-scan reset: assert `reset`=0 at `rd_addr`=5 → `rd_en`, `SyncVB` and the addresses go to 0 immediately, both `Buf*Empty`=1, and there is no scan until a new full buffer exists.
